// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for alu_seq.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_LUI     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_MULU    = 4'b1000;
    localparam logic [3:0] OP_DIVU    = 4'b1010;
    localparam logic [3:0] OP_SLL_ALT = 4'b1101;
    localparam logic [3:0] OP_SRA     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_shifter.sv
// Log2-stage barrel shifter: sll / srl / sra of data by shamt.
// Latency: combinational. Backpressure: none.
module alu_seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    input  logic               right,
    output logic [WIDTH-1:0]   result
);

    logic [WIDTH-1:0] stage;

    always_comb begin
        stage = data;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (shamt[i]) begin
                if (!right)
                    stage = stage << (1 << i);
                else if (arith)
                    stage = WIDTH'($signed(stage) >>> (1 << i));
                else
                    stage = stage >> (1 << i);
            end
        end
        result = stage;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with iterative unsigned mul/div; optional V output under ALU_SEQ_OVF_EN.
// Latency: 1 cycle to Done for simple ops and div-by-zero, WIDTH+1 for mulu/divu.
// Backpressure: Busy high until Done; Start is ignored while Busy.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       Aluc,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Rhi,
`ifdef ALU_SEQ_OVF_EN
    output logic             V,
`endif
    output logic             Z
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opd_q;      // multiplicand or divisor
    logic [WIDTH-1:0] acc_hi_q;   // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] r_q, rhi_q;
    logic             last_iter;

    logic [WIDTH-1:0] sum, diff, shift_out, single_r;
    logic             single_v;

    assign sum       = X + Y;
    assign diff      = X - Y;
    assign last_iter = (cnt_q == CNT_W'(1));

    alu_seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .data   (Y),
        .shamt  (X[SHAMT_W-1:0]),
        .arith  (Aluc == OP_SRA),
        .right  ((Aluc == OP_SRL) || (Aluc == OP_SRA)),
        .result (shift_out)
    );

    always_comb begin
        single_r = '0;
        single_v = 1'b0;
        case (Aluc)
            OP_ADD: begin
                single_r = sum;
                single_v = (X[WIDTH-1] == Y[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                single_r = diff;
                single_v = (X[WIDTH-1] != Y[WIDTH-1]) && (diff[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND:                         single_r = X & Y;
            OP_OR:                          single_r = X | Y;
            OP_XOR:                         single_r = X ^ Y;
            OP_LUI:                         single_r = {Y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLL, OP_SLL_ALT, OP_SRL, OP_SRA: single_r = shift_out;
            default:                        single_r = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;
    logic             div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_ge    = ~div_diff[WIDTH];
        div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        div_lo_n  = {acc_lo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        Busy    = (state_q != IDLE);
        Done    = (state_q == FIN);
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Aluc == OP_MULU)
                        state_d = MUL;
                    else if ((Aluc == OP_DIVU) && (Y != '0))
                        state_d = DIV;
                    else
                        state_d = FIN;
                end
            end
            MUL, DIV: if (last_iter) state_d = FIN;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    logic v_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q    <= '0;
            opd_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            r_q      <= '0;
            rhi_q    <= '0;
            v_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (Aluc == OP_MULU) begin
                            opd_q    <= X;
                            acc_hi_q <= '0;
                            acc_lo_q <= Y;
                            cnt_q    <= CNT_W'(WIDTH);
                        end else if (Aluc == OP_DIVU) begin
                            if (Y != '0) begin
                                opd_q    <= Y;
                                acc_hi_q <= '0;
                                acc_lo_q <= X;
                                cnt_q    <= CNT_W'(WIDTH);
                            end else begin
                                r_q   <= '1;
                                rhi_q <= X;
                                v_q   <= 1'b0;
                            end
                        end else begin
                            r_q   <= single_r;
                            rhi_q <= '0;
                            v_q   <= single_v;
                        end
                    end
                end
                MUL: begin
                    acc_hi_q <= mul_hi_n;
                    acc_lo_q <= mul_lo_n;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        r_q   <= mul_lo_n;
                        rhi_q <= mul_hi_n;
                        v_q   <= 1'b0;
                    end
                end
                DIV: begin
                    acc_hi_q <= div_hi_n;
                    acc_lo_q <= div_lo_n;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (last_iter) begin
                        r_q   <= div_lo_n;
                        rhi_q <= div_hi_n;
                        v_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign R   = r_q;
    assign Rhi = rhi_q;
    assign Z   = ~|r_q;

`ifdef ALU_SEQ_OVF_EN
    assign V = v_q;
`else
    logic unused_v;
    assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32); V is checked when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst, Start, Busy, Done, Z;
    logic [W-1:0] X, Y, R, Rhi;
    logic [3:0]   Aluc;
`ifdef ALU_SEQ_OVF_EN
    logic         V;
`endif

    always #5 Clk = ~Clk;

    alu_seq #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .X     (X),
        .Y     (Y),
        .Aluc  (Aluc),
        .Busy  (Busy),
        .Done  (Done),
        .R     (R),
        .Rhi   (Rhi),
`ifdef ALU_SEQ_OVF_EN
        .V     (V),
`endif
        .Z     (Z)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] rhi;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        case (op)
            4'b0000: begin
                e.r = x + y;
                e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            4'b0001: begin
                e.r = x - y;
                e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
            end
            4'b0010: e.r = x & y;
            4'b0011: e.r = x | y;
            4'b0100: e.r = x ^ y;
            4'b0110: e.r = {y[15:0], 16'h0000};
            4'b0101, 4'b1101: e.r = y << x[4:0];
            4'b0111: e.r = y >> x[4:0];
            4'b1111: e.r = W'($signed(y) >>> x[4:0]);
            4'b1000: begin
                p     = 64'(x) * 64'(y);
                e.r   = p[31:0];
                e.rhi = p[63:32];
            end
            4'b1010: begin
                if (y == 0) begin
                    e.r   = '1;
                    e.rhi = x;
                end else begin
                    e.r   = x / y;
                    e.rhi = x % y;
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " done_without_pending_op"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " R"}, 64'(R), 64'(e.r));
            check({tag, " Rhi"}, 64'(Rhi), 64'(e.rhi));
            check({tag, " Z"}, 64'(Z), 64'(e.r == 0));
`ifdef ALU_SEQ_OVF_EN
            check({tag, " V"}, 64'(V), 64'(e.v));
`endif
        end
    endtask

    // Drives one op, optionally pokes Start mid-op, then tries a Start in the Done cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int lat_exp, input int poke_at);
        int lat, busy_n;
        bit got;
        @(negedge Clk);
        Aluc  = op;
        X     = x;
        Y     = y;
        Start = 1'b1;
        sb.push_back(model(op, x, y));
        @(posedge Clk);
        #1;
        Start = 1'b0;
        X     = $urandom;
        Y     = $urandom;
        Aluc  = 4'($urandom);
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && lat < 100) begin
            @(negedge Clk);
            lat++;
            if (Busy) busy_n++;
            if (Done) begin
                got = 1'b1;
            end else if (poke_at != 0 && lat == poke_at) begin
                Start = 1'b1;
                Aluc  = 4'b0000;
                X     = 32'd3;
                Y     = 32'd4;
            end else begin
                Start = 1'b0;
            end
        end
        check({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(lat), 64'(lat_exp));
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat_exp));
            compare_result(tag);
            Start = 1'b1;
            Aluc  = 4'b0000;
            X     = 32'd1;
            Y     = 32'd1;
            @(posedge Clk);
            #1;
            Start = 1'b0;
            @(negedge Clk);
            check({tag, " start_in_done_ignored"}, {62'd0, Busy, Done}, 64'd0);
        end else begin
            sb.delete();
        end
    endtask

    function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] y);
        if (op == 4'b1000 || (op == 4'b1010 && y != 0)) return W + 1;
        return 1;
    endfunction

    initial begin
        int dn;
        logic [3:0] ops [14];
        logic [3:0] op;
        logic [W-1:0] rx, ry;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'ha, 4'hd, 4'hf, 4'h9, 4'he};

        Rst = 1'b1; Start = 1'b0; X = '0; Y = '0; Aluc = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset Busy", 64'(Busy), 64'd0);
        check("reset Done", 64'(Done), 64'd0);
        check("reset R", 64'(R), 64'd0);
        check("reset Rhi", 64'(Rhi), 64'd0);
        check("reset Z", 64'(Z), 64'd1);
        Rst = 1'b0;

        run_op("sub_eq",    4'b0001, 32'd5, 32'd5, 1, 0);
        run_op("add_wrap",  4'b0000, 32'hFFFFFFFF, 32'd1, 1, 0);
        run_op("sra",       4'b1111, 32'd4, 32'h80000000, 1, 0);
        run_op("srl",       4'b0111, 32'd4, 32'h80000000, 1, 0);
        run_op("sll",       4'b0101, 32'd31, 32'd1, 1, 0);
        run_op("sll_alt",   4'b1101, 32'd8, 32'h00ABCDEF, 1, 0);
        run_op("lui",       4'b0110, 32'd0, 32'h00001234, 1, 0);
        run_op("mulu_max",  4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, W + 1, 0);
        run_op("divu",      4'b1010, 32'd100, 32'd7, W + 1, 0);
        run_op("divu_zero", 4'b1010, 32'd9, 32'd0, 1, 0);
        run_op("mulu_poke", 4'b1000, 32'd123456, 32'd7890, W + 1, 10);

        // Abort a divide with Rst partway through
        @(negedge Clk);
        Aluc = 4'b1010; X = 32'd1000; Y = 32'd3; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        dn = 0;
        repeat (9) begin
            @(negedge Clk);
            if (Done) dn++;
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("abort Busy", 64'(Busy), 64'd0);
        check("abort Done", 64'(Done), 64'd0);
        check("abort R", 64'(R), 64'd0);
        check("abort Rhi", 64'(Rhi), 64'd0);
        check("abort Z", 64'(Z), 64'd1);
        repeat (40) begin
            @(negedge Clk);
            if (Done) dn++;
        end
        check("abort no_done", 64'(dn), 64'd0);
        run_op("add_after_abort", 4'b0000, 32'd20, 32'd22, 1, 0);

        run_op("ovf_add", 4'b0000, 32'h7FFFFFFF, 32'd1, 1, 0);
        run_op("ovf_sub", 4'b0001, 32'h80000000, 32'd1, 1, 0);
        run_op("and",     4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0);
        run_op("or",      4'b0011, 32'hF0F0F0F0, 32'h0F000000, 1, 0);
        run_op("xor",     4'b0100, 32'hAAAA5555, 32'hFFFF0000, 1, 0);
        run_op("undef",   4'b1001, 32'h12345678, 32'h9ABCDEF0, 1, 0);

        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 13)];
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if (op == 4'b1010 && ($urandom_range(0, 1) == 1)) ry = ry >> $urandom_range(0, 31);
            run_op("rand", op, rx, ry, lat_of(op, ry), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
